// File: rtl/nou_sched_pkg.sv
// Shared types and default sizing for the NOU grant scheduler.
package nou_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } sched_state_e;

    localparam int NOU_NUM_REQ_DEFAULT     = 8;
    localparam int NOU_INDEX_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/find_first_one_index_backward.sv
// Backward find-first-one: returns the index of the highest set bit of i_vector.
module find_first_one_index_backward #(
    parameter int VECTOR_LENGTH    = 8,
    parameter int MAX_OUTPUT_WIDTH = 3
) (
    input  logic [VECTOR_LENGTH-1:0]    i_vector,
    output logic [MAX_OUTPUT_WIDTH-1:0] o_index,
    output logic                        o_found
);

    // Ascending scan: the last hit written is the highest set bit.
    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            if (i_vector[i]) begin
                o_index = MAX_OUTPUT_WIDTH'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nou_grant_scheduler.sv
// Batch grant scheduler: one grant per set request bit, highest index first.
// Optional NOU_GRANT_ROUND_ROBIN_EN resumes each search below the previous grant.
module nou_grant_scheduler
    import nou_sched_pkg::*;
#(
    parameter int NUM_REQ     = NOU_NUM_REQ_DEFAULT,
    parameter int INDEX_WIDTH = NOU_INDEX_WIDTH_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   request_valid_in,
    input  logic [NUM_REQ-1:0]     request_vector_in,
    output logic                   request_ready_out,
    output logic                   grant_valid_out,
    output logic [INDEX_WIDTH-1:0] grant_index_out,
    input  logic                   grant_ready_in,
    input  logic                   flush_in,
    output logic [NUM_REQ-1:0]     pending_vector_out,
    output logic [INDEX_WIDTH:0]   grant_count_out,
    output logic                   batch_done_out,
    output logic                   busy_out
);

    sched_state_e            r_state, w_next_state;
    logic [NUM_REQ-1:0]      r_pending;
    logic                    r_grant_valid;
    logic [INDEX_WIDTH-1:0]  r_grant_index;
    logic [INDEX_WIDTH:0]    r_grant_count;

    logic                    w_batch_hs;
    logic                    w_grant_hs;
    logic [NUM_REQ-1:0]      w_pending_upd;
    logic [INDEX_WIDTH-1:0]  w_idx_all;
    logic                    w_found_all;
    logic [INDEX_WIDTH-1:0]  w_enc_idx;

    assign request_ready_out  = (r_state == IDLE);
    assign busy_out           = (r_state != IDLE);
    assign batch_done_out     = (r_state == DONE);
    assign grant_valid_out    = r_grant_valid;
    assign grant_index_out    = r_grant_index;
    assign pending_vector_out = r_pending;
    assign grant_count_out    = r_grant_count;

    assign w_batch_hs = request_valid_in & request_ready_out & ~flush_in;
    assign w_grant_hs = r_grant_valid & grant_ready_in;

    // In SELECT no grant is in flight, so this is simply the pending vector.
    assign w_pending_upd = w_grant_hs ? (r_pending & ~(NUM_REQ'(1) << r_grant_index))
                                      : r_pending;

    find_first_one_index_backward #(
        .VECTOR_LENGTH    (NUM_REQ),
        .MAX_OUTPUT_WIDTH (INDEX_WIDTH)
    ) u_ffo_all (
        .i_vector (w_pending_upd),
        .o_index  (w_idx_all),
        .o_found  (w_found_all)
    );

`ifdef NOU_GRANT_ROUND_ROBIN_EN
    logic [INDEX_WIDTH-1:0] r_last_grant;
    logic [INDEX_WIDTH-1:0] w_last_next;
    logic [NUM_REQ-1:0]     w_masked;
    logic [INDEX_WIDTH-1:0] w_idx_masked;
    logic                   w_found_masked;

    // The search must start below the grant being accepted this very cycle.
    assign w_last_next = w_grant_hs ? r_grant_index : r_last_grant;
    assign w_masked    = w_pending_upd & ((NUM_REQ'(1) << w_last_next) - NUM_REQ'(1));

    find_first_one_index_backward #(
        .VECTOR_LENGTH    (NUM_REQ),
        .MAX_OUTPUT_WIDTH (INDEX_WIDTH)
    ) u_ffo_masked (
        .i_vector (w_masked),
        .o_index  (w_idx_masked),
        .o_found  (w_found_masked)
    );

    assign w_enc_idx = w_found_masked ? w_idx_masked : w_idx_all;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_last_grant <= '0;
        end else if (w_grant_hs && !flush_in) begin
            r_last_grant <= r_grant_index;
        end
    end
`else
    assign w_enc_idx = w_idx_all;
`endif

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_in) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_batch_hs) w_next_state = (|request_vector_in) ? SELECT : DONE;
                SELECT:  w_next_state = ISSUE;
                ISSUE:   if (w_grant_hs && !w_found_all) w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Flush has priority over both batch acceptance and a grant handshake.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_pending     <= '0;
            r_grant_valid <= 1'b0;
            r_grant_index <= '0;
            r_grant_count <= '0;
        end else if (flush_in) begin
            r_pending     <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_batch_hs) begin
                        r_pending     <= request_vector_in;
                        r_grant_count <= '0;
                    end
                end
                SELECT: begin
                    r_grant_valid <= 1'b1;
                    r_grant_index <= w_enc_idx;
                end
                ISSUE: begin
                    if (w_grant_hs) begin
                        r_pending     <= w_pending_upd;
                        r_grant_count <= r_grant_count + {{INDEX_WIDTH{1'b0}}, 1'b1};
                        if (w_found_all) begin
                            r_grant_index <= w_enc_idx;
                        end else begin
                            r_grant_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nou_grant_scheduler.sv
// Scoreboard bench for nou_grant_scheduler (ordering, stalls, flush, reset, RR mode).
module tb_nou_grant_scheduler;

    logic       clk_in = 1'b0;
    logic       reset_n_in = 1'b0;
    logic       request_valid_in = 1'b0;
    logic [7:0] request_vector_in = '0;
    logic       request_ready_out;
    logic       grant_valid_out;
    logic [2:0] grant_index_out;
    logic       grant_ready_in = 1'b0;
    logic       flush_in = 1'b0;
    logic [7:0] pending_vector_out;
    logic [3:0] grant_count_out;
    logic       batch_done_out;
    logic       busy_out;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int sb_exp;

    nou_grant_scheduler #(.NUM_REQ(8), .INDEX_WIDTH(3)) dut (
        .clk_in             (clk_in),
        .reset_n_in         (reset_n_in),
        .request_valid_in   (request_valid_in),
        .request_vector_in  (request_vector_in),
        .request_ready_out  (request_ready_out),
        .grant_valid_out    (grant_valid_out),
        .grant_index_out    (grant_index_out),
        .grant_ready_in     (grant_ready_in),
        .flush_in           (flush_in),
        .pending_vector_out (pending_vector_out),
        .grant_count_out    (grant_count_out),
        .batch_done_out     (batch_done_out),
        .busy_out           (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    // Scoreboard: every accepted (non-flushed) grant must match the next expected index.
    always @(negedge clk_in) begin
        if (reset_n_in && grant_valid_out && grant_ready_in && !flush_in) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                check("sb_grant_idx", 32'(grant_index_out), sb_exp);
            end
        end
    end

    task automatic run_batch(input logic [7:0] vec);
        request_valid_in  = 1'b1;
        request_vector_in = vec;
        grant_ready_in    = 1'b1;
        step;
        request_valid_in  = 1'b0;
        for (int k = 0; k < 40 && busy_out; k++) step;
        check("rb_idle", 32'(busy_out), 0);
        check("rb_count", 32'(grant_count_out), $countones(vec));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_ready", 32'(request_ready_out), 1);
        check("rst_valid", 32'(grant_valid_out), 0);
        check("rst_count", 32'(grant_count_out), 0);
        check("rst_busy",  32'(busy_out), 0);
        step;
        reset_n_in = 1'b1;
        step;

        // Test 1: descending back-to-back grants
        request_valid_in = 1'b1; request_vector_in = 8'b1010_0110; grant_ready_in = 1'b1;
        exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(1);
        step;
        request_valid_in = 1'b0;
        @(negedge clk_in);
        check("t1_sel_valid", 32'(grant_valid_out), 0);
        check("t1_sel_busy",  32'(busy_out), 1);
        step;
        @(negedge clk_in);
        check("t1_first_idx", 32'(grant_index_out), 7);
        check("t1_first_vld", 32'(grant_valid_out), 1);
        check("t1_pending",   32'(pending_vector_out), 32'hA6);
        for (int k = 0; k < 3; k++) begin
            step;
            @(negedge clk_in);
            check("t1_b2b_vld", 32'(grant_valid_out), 1);
        end
        check("t1_last_idx", 32'(grant_index_out), 1);
        step;
        @(negedge clk_in);
        check("t1_done",     32'(batch_done_out), 1);
        check("t1_vld_low",  32'(grant_valid_out), 0);
        check("t1_count",    32'(grant_count_out), 4);
        step;
        @(negedge clk_in);
        check("t1_done_end", 32'(batch_done_out), 0);
        check("t1_ready",    32'(request_ready_out), 1);

        // Test 2: stall holds the grant stable; requests ignored while busy
        step;
        request_valid_in = 1'b1; request_vector_in = 8'b0000_0011; grant_ready_in = 1'b0;
        exp_q.push_back(1); exp_q.push_back(0);
        step;
        request_valid_in = 1'b0;
        step;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin request_valid_in = 1'b1; request_vector_in = 8'hFF; end
            if (k == 2) request_valid_in = 1'b0;
            if (k == 3) grant_ready_in = 1'b1;
            @(negedge clk_in);
            check("t2_hold_vld", 32'(grant_valid_out), 1);
            check("t2_hold_idx", 32'(grant_index_out), 1);
            if (k == 2) check("t2_pending", 32'(pending_vector_out), 32'h03);
            step;
        end
        @(negedge clk_in);
        check("t2_idx0", 32'(grant_index_out), 0);
        step;
        @(negedge clk_in);
        check("t2_done",  32'(batch_done_out), 1);
        check("t2_count", 32'(grant_count_out), 2);
        step;

        // Test 3: empty batch
        request_valid_in = 1'b1; request_vector_in = 8'h00;
        step;
        request_valid_in = 1'b0;
        @(negedge clk_in);
        check("t3_done", 32'(batch_done_out), 1);
        check("t3_vld",  32'(grant_valid_out), 0);
        step;
        @(negedge clk_in);
        check("t3_ready", 32'(request_ready_out), 1);
        check("t3_count", 32'(grant_count_out), 0);
        check("t3_done_end", 32'(batch_done_out), 0);

        // Test 4: flush on the third handshake
        step;
        request_valid_in = 1'b1; request_vector_in = 8'hFF; grant_ready_in = 1'b1;
        exp_q.push_back(7); exp_q.push_back(6);
        step;
        request_valid_in = 1'b0;
        step;
        step;
        step;
        flush_in = 1'b1;
        @(negedge clk_in);
        check("t4_idx5", 32'(grant_index_out), 5);
        step;
        flush_in = 1'b0;
        @(negedge clk_in);
        check("t4_vld",     32'(grant_valid_out), 0);
        check("t4_pending", 32'(pending_vector_out), 0);
        check("t4_count",   32'(grant_count_out), 2);
        check("t4_done",    32'(batch_done_out), 0);
        check("t4_ready",   32'(request_ready_out), 1);
        step;
        @(negedge clk_in);
        check("t4_done_after", 32'(batch_done_out), 0);

        // Test 5: asynchronous reset mid-ISSUE
        step;
        request_valid_in = 1'b1; request_vector_in = 8'h0C; grant_ready_in = 1'b0;
        step;
        request_valid_in = 1'b0;
        step;
        @(negedge clk_in);
        check("t5_pre_vld", 32'(grant_valid_out), 1);
        check("t5_pre_idx", 32'(grant_index_out), 3);
        #2;
        reset_n_in = 1'b0;
        #1;
        check("t5_rst_vld",     32'(grant_valid_out), 0);
        check("t5_rst_idx",     32'(grant_index_out), 0);
        check("t5_rst_pending", 32'(pending_vector_out), 0);
        check("t5_rst_count",   32'(grant_count_out), 0);
        check("t5_rst_busy",    32'(busy_out), 0);
        check("t5_rst_ready",   32'(request_ready_out), 1);
        check("t5_rst_done",    32'(batch_done_out), 0);
        step;
        reset_n_in = 1'b1;
        step;
        exp_q.push_back(0);
        run_batch(8'h01);

        // Test 6: order across batches (wraps in round-robin mode)
        step;
        exp_q.push_back(7); exp_q.push_back(4);
        run_batch(8'b1001_0000);
        step;
`ifdef NOU_GRANT_ROUND_ROBIN_EN
        exp_q.push_back(2); exp_q.push_back(7); exp_q.push_back(5);
`else
        exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2);
`endif
        run_batch(8'b1010_0100);
        step;

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
